// File: rtl/prefetch_responder.sv
// -----------------------------------------------------------------------------
// prefetch_responder
//
// Streams a burst of 2^PREFETCH_WIDTH symbol pairs (S[x0-k], T[y0-k]) out of
// two host-loaded symbol buffers. It serves "current block" and "prefetch
// block" requests and has a one-deep pending slot. That slot lets a follow-on
// burst start on the cycle after pf_last with no gap.
//
// Optional feature macro: PREFETCH_OOB_FLAG_EN adds output pf_oob. pf_oob is
// high on beats where either index ran below zero.
//
// Ports
//   clk                      single clock, rising edge
//   reset_i                  asynchronous active-high reset
//   prefetch_request[1:0]    01 current block, 10 prefetch block, 00 none,
//                            11 illegal
//   in_block_x/y_startpoint  start indices for a current-block request
//   prefetch_x/y_startpoint  start indices for a prefetch-block request
//   done                     aborts any stream and clears the pending slot
//   seq_we/seq_sel/seq_addr/seq_data
//                            host write port (seq_sel 0 = S, 1 = T)
//   pf_S, pf_T               streamed symbols (zero when pf_valid is low)
//   pf_valid, pf_last        beat strobe, final beat of a burst
//   pf_target                0 current block, 1 prefetch block
//   pf_count                 beats remaining after this one
//   pf_busy                  high while streaming
//   err                      sticky: illegal request or dropped request
//   pf_oob                   (PREFETCH_OOB_FLAG_EN only) index underflow flag
// -----------------------------------------------------------------------------
`ifndef POSITION_WIDTH
`define POSITION_WIDTH 6
`endif
`ifndef BP_WIDTH
`define BP_WIDTH 2
`endif
`ifndef PREFETCH_WIDTH
`define PREFETCH_WIDTH 5
`endif

module prefetch_responder (
  input  logic                       clk,
  input  logic                       reset_i,
  input  logic [1:0]                 prefetch_request,
  input  logic [`POSITION_WIDTH-1:0] in_block_x_startpoint,
  input  logic [`POSITION_WIDTH-1:0] in_block_y_startpoint,
  input  logic [`POSITION_WIDTH-1:0] prefetch_x_startpoint,
  input  logic [`POSITION_WIDTH-1:0] prefetch_y_startpoint,
  input  logic                       done,
  input  logic                       seq_we,
  input  logic                       seq_sel,
  input  logic [`POSITION_WIDTH-1:0] seq_addr,
  input  logic [`BP_WIDTH-1:0]       seq_data,
  output logic [`BP_WIDTH-1:0]       pf_S,
  output logic [`BP_WIDTH-1:0]       pf_T,
  output logic                       pf_valid,
  output logic                       pf_last,
  output logic                       pf_target,
  output logic [`PREFETCH_WIDTH-1:0] pf_count,
  output logic                       pf_busy,
`ifdef PREFETCH_OOB_FLAG_EN
  output logic                       pf_oob,
`endif
  output logic                       err
);

  localparam int POS_W   = `POSITION_WIDTH;
  localparam int DATA_W  = `BP_WIDTH;
  localparam int CNT_W   = `PREFETCH_WIDTH;
  localparam int DEPTH   = 1 << POS_W;

  localparam logic signed [POS_W:0] IDX_ONE = 1;
  localparam logic [CNT_W-1:0]      CNT_ONE = 1;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t state;

  logic [DATA_W-1:0] s_mem [DEPTH];
  logic [DATA_W-1:0] t_mem [DEPTH];

  // Index for the next beat of the running burst
  logic signed [POS_W:0] ptr_x_p0, ptr_y_p0;

  // Pending slot
  logic             pend_vld;
  logic             pend_tgt;
  logic [POS_W-1:0] pend_x, pend_y;

  // Request decode and launch selection
  logic             req_legal, req_tgt, last_now;
  logic             launch_pend, launch_req, launch, cont, to_pend, drop, err_set;
  logic [POS_W-1:0] req_x, req_y, lx, ly;
  logic             ltgt;

  logic signed [POS_W:0] beat_x, beat_y;
  logic [DATA_W-1:0]     s_beat, t_beat;
  logic [CNT_W-1:0]      cnt_next;
  logic                  oob_beat;

  // A negative index reads as zero.
  function automatic logic [DATA_W-1:0] zero_pad(input logic signed [POS_W:0] idx,
                                                 input logic [DATA_W-1:0]     raw);
    return (idx < 0) ? '0 : raw;
  endfunction

  // Symbol buffers: no reset, so contents survive reset_i. A read in the
  // same cycle as a write to that address sees the old value, because the
  // output registers sample the array before the write commits.
  always_ff @(posedge clk) begin
    if (seq_we && !seq_sel) s_mem[seq_addr] <= seq_data;
    if (seq_we &&  seq_sel) t_mem[seq_addr] <= seq_data;
  end

  always_comb begin
    req_legal = (prefetch_request == 2'b01) || (prefetch_request == 2'b10);
    req_tgt   = (prefetch_request == 2'b10);
    req_x     = req_tgt ? prefetch_x_startpoint : in_block_x_startpoint;
    req_y     = req_tgt ? prefetch_y_startpoint : in_block_y_startpoint;
    last_now  = (state == STREAM) && pf_last;

    // A pending burst launches directly after pf_last. If the slot is empty
    // at that point, a request arriving on the last beat launches instead.
    launch_pend = !done && last_now && pend_vld;
    launch_req  = !done && req_legal && ((state == IDLE) || (last_now && !pend_vld));
    launch      = launch_pend || launch_req;
    cont        = !done && (state == STREAM) && !pf_last;

    // The slot frees on the same edge its burst launches, so a request
    // arriving then can take it.
    to_pend = !done && req_legal && (state == STREAM) && !launch_req &&
              (!pend_vld || launch_pend);
    drop    = !done && req_legal && (state == STREAM) && pend_vld && !launch_pend;
    err_set = drop || (prefetch_request == 2'b11);

    lx   = launch_pend ? pend_x   : req_x;
    ly   = launch_pend ? pend_y   : req_y;
    ltgt = launch_pend ? pend_tgt : req_tgt;

    beat_x   = launch ? $signed({1'b0, lx}) : ptr_x_p0;
    beat_y   = launch ? $signed({1'b0, ly}) : ptr_y_p0;
    s_beat   = zero_pad(beat_x, s_mem[beat_x[POS_W-1:0]]);
    t_beat   = zero_pad(beat_y, t_mem[beat_y[POS_W-1:0]]);
    cnt_next = launch ? '1 : (pf_count - CNT_ONE);
    oob_beat = (beat_x < 0) || (beat_y < 0);
  end

  // Control and registered outputs
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state     <= IDLE;
      pend_vld  <= 1'b0;
      err       <= 1'b0;
      pf_valid  <= 1'b0;
      pf_last   <= 1'b0;
      pf_target <= 1'b0;
      pf_count  <= '0;
      pf_S      <= '0;
      pf_T      <= '0;
      pf_busy   <= 1'b0;
`ifdef PREFETCH_OOB_FLAG_EN
      pf_oob    <= 1'b0;
`endif
    end else begin
      err <= err | err_set;

      if (done)             pend_vld <= 1'b0;
      else if (to_pend)     pend_vld <= 1'b1;
      else if (launch_pend) pend_vld <= 1'b0;

      if (launch || cont) begin
        state    <= STREAM;
        pf_busy  <= 1'b1;
        pf_valid <= 1'b1;
        pf_S     <= s_beat;
        pf_T     <= t_beat;
        pf_count <= cnt_next;
        pf_last  <= (cnt_next == '0);
        if (launch) pf_target <= ltgt;
`ifdef PREFETCH_OOB_FLAG_EN
        pf_oob   <= oob_beat;
`endif
      end else begin
        state     <= IDLE;
        pf_busy   <= 1'b0;
        pf_valid  <= 1'b0;
        pf_S      <= '0;
        pf_T      <= '0;
        pf_count  <= '0;
        pf_last   <= 1'b0;
        pf_target <= 1'b0;
`ifdef PREFETCH_OOB_FLAG_EN
        pf_oob    <= 1'b0;
`endif
      end
    end
  end

  // Datapath registers: index pointers and captured pending startpoints
  always_ff @(posedge clk) begin
    if (launch || cont) begin
      ptr_x_p0 <= beat_x - IDX_ONE;
      ptr_y_p0 <= beat_y - IDX_ONE;
    end
    if (to_pend) begin
      pend_x   <= req_x;
      pend_y   <= req_y;
      pend_tgt <= req_tgt;
    end
  end

`ifndef PREFETCH_OOB_FLAG_EN
  logic unused_oob;
  assign unused_oob = oob_beat;
`endif

endmodule

// File: doc/prefetch_responder.md
PREFETCH_RESPONDER -- requirements
Module: prefetch_responder

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state on rising edge.
REQ-002 SHALL have ports: reset_i  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: prefetch_request  in  2  01=current block, 10=prefetch block, 00=none, 11=illegal.
REQ-004 SHALL have ports: in_block_x_startpoint, in_block_y_startpoint, prefetch_x_startpoint, prefetch_y_startpoint  in  `POSITION_WIDTH each  down-right start indices.
REQ-005 SHALL have ports: done  in  1  traceback finished; aborts any stream.
REQ-006 SHALL have ports: seq_we  in  1; seq_sel  in  1 (0=S, 1=T); seq_addr  in  `POSITION_WIDTH; seq_data  in  `BP_WIDTH  host load port for sequence buffers.
REQ-007 SHALL have ports: pf_S, pf_T  out  `BP_WIDTH each  streamed symbols; pf_valid  out  1; pf_last  out  1; pf_target  out  1 (0=current, 1=prefetch); pf_count  out  `PREFETCH_WIDTH  beat countdown; pf_busy  out  1; err  out  1 (sticky).

Function
REQ-008 SHALL hold two symbol buffers, S and T, each 2^`POSITION_WIDTH entries of `BP_WIDTH bits, written only via seq_we.
REQ-009 SHALL use FSM states IDLE, STREAM. Transitions: IDLE->STREAM on a legal request; STREAM->IDLE after the last beat or on done.
REQ-010 In IDLE, a request of 01 or 10 SHALL be sampled at edge E. The matching x/y startpoints and target SHALL be captured at edge E.
REQ-011 Burst length SHALL be B = 2^`PREFETCH_WIDTH beats, with pf_valid high on B consecutive cycles starting the cycle after E. There is no backpressure.
REQ-012 Beat k (k = 0..B-1) SHALL drive pf_S = S[x0-k], pf_T = T[y0-k], and pf_count = B-1-k.
REQ-013 pf_last SHALL be high only on beat B-1. The FSM SHALL be in IDLE on the next cycle, and a new request may be sampled in that same cycle.
REQ-014 When x0-k or y0-k is negative, that symbol SHALL be driven as zero. Index arithmetic SHALL use `POSITION_WIDTH+1 signed bits.
REQ-015 pf_busy SHALL be high in STREAM and low in IDLE.
REQ-016 A request arriving in STREAM SHALL be latched into a one-deep pending slot, with its startpoints captured. The pending request SHALL start on the cycle after pf_last, with no gap beat.
REQ-017 A request arriving while the pending slot is full SHALL be dropped and SHALL set err.
REQ-018 A request of 11 SHALL be ignored and SHALL set err.
REQ-019 On done, the stream SHALL stop at the next edge and the pending slot SHALL be cleared. pf_valid SHALL be low from the next cycle. done has priority over a simultaneous request.
REQ-020 A write to an address being read in the same cycle SHALL return the old value (read-before-write).
REQ-021 When pf_valid is low, pf_S, pf_T, pf_count and pf_last SHALL be zero.

Reset
REQ-022 reset_i SHALL immediately force IDLE, clear the pending slot, and drive all outputs to 0 (including err).
REQ-023 Buffer contents SHALL NOT be reset.
REQ-024 Assertion mid-stream SHALL truncate the stream without completing any beat.

Configuration
REQ-025 With PREFETCH_OOB_FLAG_EN defined, there SHALL be an extra output pf_oob (1 bit), high on beats where either index underflowed per REQ-014, and zero otherwise.
REQ-026 Without PREFETCH_OOB_FLAG_EN, the pf_oob port SHALL be absent and zero-padding SHALL be unchanged.

Verification
REQ-027 Load S[i]=i%4 and T[i]=(i+1)%4, then request 01 with in_block x=40, y=40 (PREFETCH_WIDTH=5) -> 32 beats on the cycles after E; beat0 pf_S=0, pf_T=1, pf_count=31; pf_last on beat31 with pf_count=0; pf_target=0.
REQ-028 Request 10 with prefetch x=5, y=31 -> beats 0..5 carry S data; beats 6..31 give pf_S=0; pf_T is valid for all beats; pf_oob=1 on beats 6..31 when the feature is enabled.
REQ-029 Request 01, then request 10 at beat 10, then another at beat 12 -> second burst starts immediately after pf_last with pf_target=1; third request dropped; err=1.
REQ-030 done asserted at beat 7 with a pending request present -> pf_valid low from the next cycle; no further beats; pf_busy=0.
REQ-031 reset_i pulsed asynchronously mid-beat -> all outputs 0 without waiting for a clock edge; buffer contents readable unchanged on a later request.
REQ-032 Request 11 in IDLE -> no beats; err=1; err stays 1 until reset_i.
